// File: rtl/if_fetch_unit_if.sv
// Instruction-bus bundle between the fetch unit (master) and memory (slave).
// Signal names keep the fetch unit's point of view (_o driven by the master).
interface if_fetch_unit_if;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;

   modport master (
      output instr_req_o,
      output instr_addr_o,
      input  instr_gnt_i,
      input  instr_rvalid_i,
      input  instr_rdata_i,
      input  instr_err_i
   );

   modport slave (
      input  instr_req_o,
      input  instr_addr_o,
      output instr_gnt_i,
      output instr_rvalid_i,
      output instr_rdata_i,
      output instr_err_i
   );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: credit-limited fetch, prefetch FIFO, registered ID outputs.
// Define IF_FETCH_BYPASS_EN to let responses skip an empty FIFO.
module if_fetch_unit #(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic [31:0]     redirect_pc_i,
   if_fetch_unit_if.master bus,
   output logic [31:0]     ID_instr_o,
   output logic [31:0]     ID_pc_o,
   output logic            ID_valid_o,
   output logic            ID_fetch_err_o
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] addr_q, addr_d;
   logic [31:0] rpc_q, rpc_d;
   logic [2:0]  outst_q, outst_d;
   logic [2:0]  disc_q, disc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  rd_q, rd_d;
   logic [1:0]  wr_q, wr_d;

   logic [31:0] fpc_q  [4];
   logic [31:0] fdat_q [4];
   logic        ferr_q [4];

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic req, acc, rsp, keep, push, pop, byp;
   logic [31:0] redir;

   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign redir = {redirect_pc_i[31:2], 2'b00};
   assign req   = !rst && !flush &&
                  (({1'b0, outst_q} + {1'b0, cnt_q}) < 4'(FIFO_DEPTH));
   assign acc   = req && bus.instr_gnt_i;
   // Responses without a matching grant are dropped.
   assign rsp   = bus.instr_rvalid_i && (outst_q != 3'd0);
   assign keep  = rsp && (disc_q == 3'd0) && !flush;
   assign pop   = !flush && !stall && (cnt_q != 3'd0);
`ifdef IF_FETCH_BYPASS_EN
   assign byp   = keep && (cnt_q == 3'd0) && !stall;
`else
   assign byp   = 1'b0;
`endif
   assign push  = keep && !byp;

   assign bus.instr_req_o  = req;
   assign bus.instr_addr_o = addr_q;
   assign ID_instr_o       = instr_q;
   assign ID_pc_o          = pc_q;
   assign ID_valid_o       = valid_q;
   assign ID_fetch_err_o   = err_q;

   always_comb begin
      addr_d  = addr_q;
      rpc_d   = rpc_q;
      outst_d = outst_q + {2'b00, acc} - {2'b00, rsp};
      disc_d  = disc_q;
      cnt_d   = cnt_q + {2'b00, push} - {2'b00, pop};
      rd_d    = rd_q;
      wr_d    = wr_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (acc)  addr_d = addr_q + 32'd4;
      if (rsp && disc_q != 3'd0) disc_d = disc_q - 3'd1;
      if (keep) rpc_d = rpc_q + 32'd4;
      if (push) wr_d = nxt(wr_q);
      if (pop)  rd_d = nxt(rd_q);
      if (flush) begin
         addr_d  = redir;
         rpc_d   = redir;
         cnt_d   = 3'd0;
         rd_d    = 2'd0;
         wr_d    = 2'd0;
         // Everything still in flight after this edge is stale.
         disc_d  = outst_d;
         instr_d = NOP;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (!stall) begin
         if (pop) begin
            instr_d = fdat_q[rd_q];
            pc_d    = fpc_q[rd_q];
            valid_d = 1'b1;
            err_d   = ferr_q[rd_q];
         end else if (byp) begin
            instr_d = bus.instr_rdata_i;
            pc_d    = rpc_q;
            valid_d = 1'b1;
            err_d   = bus.instr_err_i;
         end else begin
            instr_d = NOP;
            valid_d = 1'b0;
            err_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= {BOOT_ADDR[31:2], 2'b00};
         rpc_q   <= {BOOT_ADDR[31:2], 2'b00};
         outst_q <= 3'd0;
         disc_q  <= 3'd0;
         cnt_q   <= 3'd0;
         rd_q    <= 2'd0;
         wr_q    <= 2'd0;
         instr_q <= NOP;
         pc_q    <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         rpc_q   <= rpc_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fpc_q[wr_q]  <= rpc_q;
         fdat_q[wr_q] <= bus.instr_rdata_i;
         ferr_q[wr_q] <= bus.instr_err_i;
      end
   end

   a_rsp_credit : assert property (
      @(posedge clk) disable iff (rst)
      bus.instr_rvalid_i |-> (outst_q != 3'd0)
   );
endmodule
